// File: rtl/netarbiter.sv
`default_nettype none
// ============================================================================
//  Module      : netarbiter
//  Description : Round-robin packet arbiter merging NIN AXIN source streams
//                onto one outgoing stream; a grant is held for a whole packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module netarbiter #(
    parameter int NIN = 4,
    parameter int DW  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic [NIN-1:0]    S_AXIN_VALID,
    output logic [NIN-1:0]    S_AXIN_READY,
    input  logic [NIN*DW-1:0] S_AXIN_DATA,
    input  logic [NIN-1:0]    S_AXIN_LAST,
    input  logic [NIN-1:0]    S_AXIN_ABORT,

    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [DW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST,
    output logic              M_AXIN_ABORT,

    output logic [NIN-1:0]    o_grant
);

    localparam int PW = (NIN > 1) ? $clog2(NIN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } state_t;

    state_t          r_state;
    logic [NIN-1:0]  r_grant;
    logic [PW-1:0]   r_ptr;

    logic [NIN-1:0]  w_req;
    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic [NIN-1:0]  w_pick_onehot;

    logic            w_m_valid;
    logic [DW-1:0]   w_m_data;
    logic            w_m_last;
    logic            w_m_abort;
    logic            w_exit;

    // An aborting source is not a request: its beat is flushed, never granted.
    assign w_req = S_AXIN_VALID & ~S_AXIN_ABORT;

    // Search starts one past the pointer so the last winner has lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        idx     = '0;
        for (int k = 1; k <= NIN; k++) begin
            idx = PW'((int'(r_ptr) + k) % NIN);
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    assign w_pick_onehot = NIN'(1) << w_pick;

    // AND-OR mux on the one-hot grant; all zero while idle.
    always_comb begin
        w_m_valid = 1'b0;
        w_m_data  = '0;
        w_m_last  = 1'b0;
        w_m_abort = 1'b0;
        for (int n = 0; n < NIN; n++) begin
            if (r_grant[n]) begin
                w_m_valid = w_m_valid | S_AXIN_VALID[n];
                w_m_data  = w_m_data  | S_AXIN_DATA[n*DW +: DW];
                w_m_last  = w_m_last  | S_AXIN_LAST[n];
                w_m_abort = w_m_abort | S_AXIN_ABORT[n];
            end
        end
    end

    assign M_AXIN_VALID = w_m_valid & ~i_reset;
    assign M_AXIN_DATA  = w_m_data;
    assign M_AXIN_LAST  = w_m_last;
    assign M_AXIN_ABORT = w_m_abort & ~i_reset;

    generate
        for (genvar n = 0; n < NIN; n++) begin : g_ready
            assign S_AXIN_READY[n] = r_grant[n] ? (M_AXIN_READY & ~i_reset)
                                                : S_AXIN_ABORT[n];
        end
    endgenerate

    assign w_exit = (M_AXIN_VALID && M_AXIN_READY && M_AXIN_LAST)
                 || (M_AXIN_ABORT && (!M_AXIN_VALID || M_AXIN_READY));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= PW'(NIN - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_PACKET;
                        r_grant <= w_pick_onehot;
                        r_ptr   <= w_pick;
                    end
                end
                ST_PACKET: begin
                    // Always drop back to idle: the grant never hops sources.
                    if (w_exit) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_grant = r_grant;

    a_grant_onehot : assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(r_grant));
    a_grant_state : assert property (@(posedge i_clk) disable iff (i_reset)
        ((r_state == ST_PACKET) == (r_grant != '0)));

endmodule
`default_nettype wire

// File: tb/tb_netarbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_netarbiter
//  Description : Directed self-checking bench for the netarbiter block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_netarbiter;

    localparam int NIN = 4;
    localparam int DW  = 32;

    logic              clk;
    logic              rst;
    logic [NIN-1:0]    s_valid;
    logic [NIN-1:0]    s_ready;
    logic [NIN*DW-1:0] s_data;
    logic [NIN-1:0]    s_last;
    logic [NIN-1:0]    s_abort;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_abort;
    logic [NIN-1:0]    grant;

    int n_tests = 0;
    int n_fail  = 0;

    netarbiter #(.NIN(NIN), .DW(DW)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .S_AXIN_VALID (s_valid),
        .S_AXIN_READY (s_ready),
        .S_AXIN_DATA  (s_data),
        .S_AXIN_LAST  (s_last),
        .S_AXIN_ABORT (s_abort),
        .M_AXIN_VALID (m_valid),
        .M_AXIN_READY (m_ready),
        .M_AXIN_DATA  (m_data),
        .M_AXIN_LAST  (m_last),
        .M_AXIN_ABORT (m_abort),
        .o_grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_valid = '0; s_data = '0; s_last = '0; s_abort = '0; m_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 0", m_valid); end
        n_tests++; if (m_abort !== 1'b0) begin n_fail++; $display("FAIL reset_mabort: got %b expected 0", m_abort); end
        n_tests++; if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_sready: got %b expected 0000", s_ready); end
        s_valid = 4'b0010; s_abort = 4'b0010; m_ready = 1'b1;
        #1;
        n_tests++; if (s_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_flush: got %b expected 0010", s_ready); end
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_abort_nogrant: got %b expected 0000", grant); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [NIN-1:0] exp_g [6];
        exp_g = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        s_valid = 4'b0101; s_last = 4'b1111; m_ready = 1'b1;
        s_data[0*DW +: DW] = 32'hA000_0000;
        s_data[2*DW +: DW] = 32'hA000_0002;
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_grant: got %b expected 0000", grant); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_mvalid: got %b expected 0", m_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, exp_g[i]); end
            n_tests++; if (m_valid !== (exp_g[i] != 0)) begin n_fail++; $display("FAIL rr_mvalid[%0d]: got %b expected %b", i, m_valid, exp_g[i] != 0); end
            n_tests++; if (s_ready !== exp_g[i]) begin n_fail++; $display("FAIL rr_sready[%0d]: got %b expected %b", i, s_ready, exp_g[i]); end
            if (exp_g[i] == 4'b0100) begin
                n_tests++; if (m_data !== 32'hA000_0002) begin n_fail++; $display("FAIL rr_data2: got %h expected a0000002", m_data); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_hold_packet();
        int  b;
        bit  done;
        do_reset();
        s_valid = 4'b0010;
        s_data[1*DW +: DW] = 32'h100;
        step();
        b = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            m_ready = (c % 2 == 0);
            s_data[1*DW +: DW] = 32'h100 + b;
            s_last[1] = (b == 4);
            if (b >= 2) begin
                s_valid[2] = 1'b1; s_data[2*DW +: DW] = 32'h200; s_last[2] = 1'b1;
            end
            #1;
            n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL hold_grant[c%0d]: got %b expected 0010", c, grant); end
            n_tests++; if (m_data !== 32'h100 + b) begin n_fail++; $display("FAIL hold_data[c%0d]: got %h expected %h", c, m_data, 32'h100 + b); end
            n_tests++; if (m_last !== (b == 4)) begin n_fail++; $display("FAIL hold_last[c%0d]: got %b expected %b", c, m_last, b == 4); end
            n_tests++; if (s_ready !== (m_ready ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL hold_sready[c%0d]: got %b expected %b", c, s_ready, m_ready ? 4'b0010 : 4'b0000); end
            if (m_ready) begin
                if (b == 4) done = 1'b1;
                b++;
            end
            step();
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL hold_timeout: got %0d beats expected 5", b); end
        s_valid[1] = 1'b0; m_ready = 1'b1;
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL hold_release: got %b expected 0000", grant); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL hold_bubble: got %b expected 0", m_valid); end
        step();
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL hold_next_grant: got %b expected 0100", grant); end
        n_tests++; if (m_data !== 32'h200) begin n_fail++; $display("FAIL hold_next_data: got %h expected 00000200", m_data); end
        s_valid[2] = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        s_valid = 4'b0001; m_ready = 1'b1;
        step();
        for (int b = 0; b < 3; b++) begin
            s_data[0*DW +: DW] = 32'h300 + b;
            #1;
            n_tests++; if (m_data !== 32'h300 + b || m_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pre_beat[%0d]: got %h/%b expected %h/1", b, m_data, m_valid, 32'h300 + b); end
            step();
        end
        s_abort[0] = 1'b1; m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++; if (m_abort !== 1'b1) begin n_fail++; $display("FAIL abort_held[%0d]: got %b expected 1", c, m_abort); end
            n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_grant_held[%0d]: got %b expected 0001", c, grant); end
            n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL abort_nolast[%0d]: got %b expected 0", c, m_last); end
            n_tests++; if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL abort_stall_ready[%0d]: got %b expected 0000", c, s_ready); end
            step();
        end
        m_ready = 1'b1;
        #1;
        n_tests++; if (s_ready !== 4'b0001 || m_abort !== 1'b1) begin n_fail++; $display("FAIL abort_deliver: got ready %b abort %b expected 0001/1", s_ready, m_abort); end
        step();
        clear_inputs();
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL abort_release: got %b expected 0000", grant); end
        n_tests++; if (m_valid !== 1'b0 || m_abort !== 1'b0) begin n_fail++; $display("FAIL abort_idle_m: got %b/%b expected 0/0", m_valid, m_abort); end
    endtask

    task automatic test_flush();
        do_reset();
        s_valid = 4'b0001; m_ready = 1'b1; s_data[0*DW +: DW] = 32'h400;
        step();
        s_valid[3] = 1'b1; s_abort[3] = 1'b1; s_data[3*DW +: DW] = 32'hDEAD;
        #1;
        n_tests++; if (s_ready !== 4'b1001) begin n_fail++; $display("FAIL flush_ready: got %b expected 1001", s_ready); end
        n_tests++; if (m_data !== 32'h400 || m_abort !== 1'b0) begin n_fail++; $display("FAIL flush_m_clean: got %h/%b expected 00000400/0", m_data, m_abort); end
        step();
        s_valid[3] = 1'b0; s_abort[3] = 1'b0;
        #1;
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL flush_grant: got %b expected 0001", grant); end
        s_last[0] = 1'b1;
        step();
        s_valid = 4'b1000; s_abort = 4'b1000; s_last = '0;
        #1;
        n_tests++; if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL flush_idle_ready: got %b expected 1000", s_ready); end
        step();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL flush_no_grant: got %b expected 0000", grant); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_valid = 4'b0100; m_ready = 1'b1; s_data[2*DW +: DW] = 32'h500;
        step();
        for (int b = 0; b < 3; b++) step();
        #1;
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant_before: got %b expected 0100", grant); end
        rst = 1'b1;
        s_valid = 4'b0101;
        step();
        rst = 1'b0;
        #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 0000", grant); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mvalid: got %b expected 0", m_valid); end
        step();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_src0_first: got %b expected 0001", grant); end
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  beat [NIN];
        int  pkt  [NIN];
        int  cnt  [NIN];
        int  exp_src;
        bit  exp_idle;
        int  packets;
        int  mn, mx;
        logic [NIN-1:0] eg;
        do_reset();
        for (int n = 0; n < NIN; n++) begin beat[n] = 0; pkt[n] = 0; cnt[n] = 0; end
        exp_src = 0; exp_idle = 1'b1; packets = 0;
        s_valid = 4'b1111;
        for (int c = 0; c < 20000 && packets < 1000; c++) begin
            for (int n = 0; n < NIN; n++) begin
                s_data[n*DW +: DW] = {8'(n), 16'(pkt[n]), 8'(beat[n])};
                s_last[n] = (beat[n] == 2);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = exp_idle ? 4'b0000 : 4'(1 << exp_src);
            n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL b2b_grant[c%0d]: got %b expected %b", c, grant, eg); end
            if (!exp_idle) begin
                n_tests++; if (m_data !== {8'(exp_src), 16'(pkt[exp_src]), 8'(beat[exp_src])}) begin n_fail++; $display("FAIL b2b_data[c%0d]: got %h expected %h", c, m_data, {8'(exp_src), 16'(pkt[exp_src]), 8'(beat[exp_src])}); end
                n_tests++; if (s_ready !== (m_ready ? eg : 4'b0000)) begin n_fail++; $display("FAIL b2b_sready[c%0d]: got %b expected %b", c, s_ready, m_ready ? eg : 4'b0000); end
            end
            if (exp_idle) begin
                exp_idle = 1'b0;
            end else if (m_ready) begin
                beat[exp_src]++;
                if (beat[exp_src] == 3) begin
                    beat[exp_src] = 0; pkt[exp_src]++; cnt[exp_src]++; packets++;
                    exp_idle = 1'b1;
                    exp_src = (exp_src + 1) % NIN;
                end
            end
            step();
        end
        n_tests++; if (packets != 1000) begin n_fail++; $display("FAIL b2b_timeout: got %0d packets expected 1000", packets); end
        mn = cnt[0]; mx = cnt[0];
        for (int n = 1; n < NIN; n++) begin
            if (cnt[n] < mn) mn = cnt[n];
            if (cnt[n] > mx) mx = cnt[n];
        end
        n_tests++; if (mx - mn > 1) begin n_fail++; $display("FAIL b2b_fairness: got spread %0d expected <= 1", mx - mn); end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_hold_packet();
        test_abort();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
